// File: rtl/i2c_reg_sequencer.sv
// i2c_reg_sequencer: turns one register read/write command into the chain of
// byte phases an I2C master core expects (address, register, data / repeated
// start, read), with core error handling, a no-progress watchdog and a
// single-cycle completion pulse back to the requester.
module i2c_reg_sequencer #(
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input  logic       clk_in,
  input  logic       reset_n,
  // user command side
  input  logic       req_valid,
  output logic       req_ready,
  input  logic       req_rw,
  input  logic [6:0] req_dev_addr,
  input  logic [7:0] req_reg_addr,
  input  logic [7:0] req_wdata,
  output logic       resp_valid,
  output logic [1:0] resp_err,
  output logic [7:0] resp_rdata,
  // I2C core side
  output logic       transfer_start,
  output logic       transfer_continues,
  output logic       mode,
  output logic [7:0] data_tx,
  input  logic       transfer_ready,
  input  logic       transaction_complete,
  input  logic       nack,
  input  logic       start_err,
  input  logic       arbitration_err,
  input  logic [7:0] data_rx
);

  localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);

  localparam logic [1:0] ERR_OK      = 2'b00;
  localparam logic [1:0] ERR_NACK    = 2'b01;
  localparam logic [1:0] ERR_CORE    = 2'b10;
  localparam logic [1:0] ERR_TIMEOUT = 2'b11;

  typedef enum logic [2:0] {
    IDLE, ISSUE, ADDR_W, REG, WDATA, ADDR_R, RDATA, STOP_WAIT
  } state_t;

  state_t          state_reg, state_next;
  logic            rw_reg, rw_next;
  logic [6:0]      dev_reg, dev_next;
  logic [7:0]      reg_addr_reg, reg_addr_next;
  logic [7:0]      wdata_reg, wdata_next;
  logic            start_reg, start_next;
  logic            cont_reg, cont_next;
  logic            mode_reg, mode_next;
  logic [7:0]      data_tx_reg, data_tx_next;
  logic            resp_valid_reg, resp_valid_next;
  logic [1:0]      resp_err_reg, resp_err_next;
  logic [7:0]      resp_rdata_reg, resp_rdata_next;
  logic [WD_W-1:0] wd_reg, wd_next;
  logic [WD_W-1:0] wd_inc;
  logic            core_err;
  logic            phase_done;

  assign wd_inc   = wd_reg + WD_W'(1);
  assign core_err = start_err | arbitration_err;
  // A completion only advances the sequence in a byte phase; in ISSUE and
  // STOP_WAIT it carries no meaning for us.
  assign phase_done = transaction_complete &&
                      (state_reg != ISSUE) && (state_reg != STOP_WAIT);

  assign req_ready          = (state_reg == IDLE);
  assign resp_valid         = resp_valid_reg;
  assign resp_err           = resp_err_reg;
  assign resp_rdata         = resp_rdata_reg;
  assign transfer_start     = start_reg;
  assign transfer_continues = cont_reg;
  assign mode               = mode_reg;
  assign data_tx            = data_tx_reg;

  // State and registered outputs; reset abandons any command silently.
  always_ff @(posedge clk_in or negedge reset_n) begin
    if (!reset_n) begin
      state_reg      <= IDLE;
      rw_reg         <= 1'b0;
      dev_reg        <= 7'h00;
      reg_addr_reg   <= 8'h00;
      wdata_reg      <= 8'h00;
      start_reg      <= 1'b0;
      cont_reg       <= 1'b0;
      mode_reg       <= 1'b0;
      data_tx_reg    <= 8'h00;
      resp_valid_reg <= 1'b0;
      resp_err_reg   <= ERR_OK;
      resp_rdata_reg <= 8'h00;
      wd_reg         <= '0;
    end else begin
      state_reg      <= state_next;
      rw_reg         <= rw_next;
      dev_reg        <= dev_next;
      reg_addr_reg   <= reg_addr_next;
      wdata_reg      <= wdata_next;
      start_reg      <= start_next;
      cont_reg       <= cont_next;
      mode_reg       <= mode_next;
      data_tx_reg    <= data_tx_next;
      resp_valid_reg <= resp_valid_next;
      resp_err_reg   <= resp_err_next;
      resp_rdata_reg <= resp_rdata_next;
      wd_reg         <= wd_next;
    end
  end

  // Next-state and next-output logic; priority is core error, then phase
  // completion, then watchdog expiry, then transfer_ready handshakes.
  always_comb begin
    state_next      = state_reg;
    rw_next         = rw_reg;
    dev_next        = dev_reg;
    reg_addr_next   = reg_addr_reg;
    wdata_next      = wdata_reg;
    start_next      = start_reg;
    cont_next       = cont_reg;
    mode_next       = mode_reg;
    data_tx_next    = data_tx_reg;
    resp_valid_next = 1'b0;
    resp_err_next   = resp_err_reg;
    resp_rdata_next = resp_rdata_reg;
    wd_next         = wd_reg;

    if (state_reg == IDLE) begin
      if (req_valid) begin
        rw_next       = req_rw;
        dev_next      = req_dev_addr;
        reg_addr_next = req_reg_addr;
        wdata_next    = req_wdata;
        start_next    = 1'b1;
        cont_next     = 1'b1;
        mode_next     = 1'b0;
        data_tx_next  = {req_dev_addr, 1'b0};
        resp_err_next = ERR_OK;
        wd_next       = '0;
        state_next    = ISSUE;
      end
    end else begin
      wd_next = transaction_complete ? '0 : wd_inc;
      if (core_err) begin
        start_next    = 1'b0;
        cont_next     = 1'b0;
        resp_err_next = ERR_CORE;
        state_next    = STOP_WAIT;
      end else if (phase_done) begin
        case (state_reg)
          ADDR_W: begin
            if (nack) begin
              start_next    = 1'b0;
              cont_next     = 1'b0;
              resp_err_next = ERR_NACK;
              state_next    = STOP_WAIT;
            end else begin
              // A read leaves continues low with start high: the core
              // issues a repeated START after the register byte.
              data_tx_next = reg_addr_reg;
              start_next   = 1'b1;
              cont_next    = ~rw_reg;
              mode_next    = 1'b0;
              state_next   = REG;
            end
          end
          REG: begin
            if (nack) begin
              start_next    = 1'b0;
              cont_next     = 1'b0;
              resp_err_next = ERR_NACK;
              state_next    = STOP_WAIT;
            end else if (rw_reg) begin
              data_tx_next = {dev_reg, 1'b1};
              start_next   = 1'b0;
              cont_next    = 1'b1;
              mode_next    = 1'b0;
              state_next   = ADDR_R;
            end else begin
              data_tx_next = wdata_reg;
              start_next   = 1'b0;
              cont_next    = 1'b0;
              state_next   = WDATA;
            end
          end
          ADDR_R: begin
            start_next = 1'b0;
            cont_next  = 1'b0;
            if (nack) begin
              resp_err_next = ERR_NACK;
              state_next    = STOP_WAIT;
            end else begin
              // Single-byte read: master NACKs it, hence continues low.
              mode_next  = 1'b1;
              state_next = RDATA;
            end
          end
          WDATA: begin
            start_next    = 1'b0;
            cont_next     = 1'b0;
            resp_err_next = nack ? ERR_NACK : ERR_OK;
            state_next    = STOP_WAIT;
          end
          RDATA: begin
            start_next      = 1'b0;
            cont_next       = 1'b0;
            resp_rdata_next = data_rx;
            resp_err_next   = ERR_OK;
            state_next      = STOP_WAIT;
          end
          default: begin
            state_next = state_reg;
          end
        endcase
      end else if (!transaction_complete && (wd_inc == WD_W'(TIMEOUT_CYCLES))) begin
        // No progress from the core: report immediately, no STOP wait.
        start_next      = 1'b0;
        cont_next       = 1'b0;
        resp_err_next   = ERR_TIMEOUT;
        resp_valid_next = 1'b1;
        wd_next         = '0;
        state_next      = IDLE;
      end else if (state_reg == ISSUE) begin
        if (transfer_ready && start_reg) begin
          state_next = ADDR_W;
        end
      end else if (state_reg == STOP_WAIT) begin
        start_next = 1'b0;
        if (transfer_ready) begin
          resp_valid_next = 1'b1;
          wd_next         = '0;
          state_next      = IDLE;
        end
      end
    end
  end

endmodule

// File: tb/tb_i2c_reg_sequencer.sv
// Directed bench for i2c_reg_sequencer: drives the core-side handshake by
// hand and checks the phase outputs and responses against hand-worked values.
module tb_i2c_reg_sequencer;

  localparam int TO = 64;

  logic       clk_in = 1'b0;
  logic       reset_n = 1'b0;
  logic       req_valid = 1'b0;
  logic       req_ready;
  logic       req_rw = 1'b0;
  logic [6:0] req_dev_addr = 7'h00;
  logic [7:0] req_reg_addr = 8'h00;
  logic [7:0] req_wdata = 8'h00;
  logic       resp_valid;
  logic [1:0] resp_err;
  logic [7:0] resp_rdata;
  logic       transfer_start;
  logic       transfer_continues;
  logic       mode;
  logic [7:0] data_tx;
  logic       transfer_ready = 1'b0;
  logic       transaction_complete = 1'b0;
  logic       nack = 1'b0;
  logic       start_err = 1'b0;
  logic       arbitration_err = 1'b0;
  logic [7:0] data_rx = 8'h00;

  int checks = 0;
  int errors = 0;
  int resp_seen = 0;

  // {start, continues, mode, data_tx} and {valid, err, rdata}
  wire [10:0] core_w = {transfer_start, transfer_continues, mode, data_tx};
  wire [10:0] resp_w = {resp_valid, resp_err, resp_rdata};

  i2c_reg_sequencer #(.TIMEOUT_CYCLES(TO)) dut (
    .clk_in(clk_in), .reset_n(reset_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_rw(req_rw),
    .req_dev_addr(req_dev_addr), .req_reg_addr(req_reg_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_err(resp_err), .resp_rdata(resp_rdata),
    .transfer_start(transfer_start), .transfer_continues(transfer_continues),
    .mode(mode), .data_tx(data_tx),
    .transfer_ready(transfer_ready), .transaction_complete(transaction_complete),
    .nack(nack), .start_err(start_err), .arbitration_err(arbitration_err),
    .data_rx(data_rx)
  );

  always #5 clk_in = ~clk_in;

  // Count completion pulses, sampled mid-cycle.
  always @(negedge clk_in) begin
    if (resp_valid === 1'b1) resp_seen++;
  end

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  task automatic accept(input logic rw, input logic [6:0] dev,
                        input logic [7:0] ra, input logic [7:0] wd);
    req_rw = rw; req_dev_addr = dev; req_reg_addr = ra; req_wdata = wd;
    req_valid = 1'b1;
    tick();
    req_valid = 1'b0;
  endtask

  task automatic complete(input logic nk, input logic [7:0] rx);
    transaction_complete = 1'b1; nack = nk; data_rx = rx;
    tick();
    transaction_complete = 1'b0; nack = 1'b0;
  endtask

  task automatic core_ready();
    transfer_ready = 1'b1;
    tick();
    transfer_ready = 1'b0;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    repeat (3) tick();
    checks++;
    if (core_w !== 11'h000) begin
      errors++; $display("FAIL rst_core got %h exp %h", core_w, 11'h000);
    end
    checks++;
    if (resp_w !== 11'h000) begin
      errors++; $display("FAIL rst_resp got %h exp %h", resp_w, 11'h000);
    end
    reset_n = 1'b1;
    tick();
    checks++;
    if (req_ready !== 1'b1) begin
      errors++; $display("FAIL rst_ready got %b exp 1", req_ready);
    end
    $display("txn reset done");
  endtask

  task automatic test_idle_ignore();
    int base;
    base = resp_seen;
    transfer_ready = 1'b1; transaction_complete = 1'b1; nack = 1'b1;
    start_err = 1'b1; arbitration_err = 1'b1; data_rx = 8'hFF;
    repeat (2) tick();
    transfer_ready = 1'b0; transaction_complete = 1'b0; nack = 1'b0;
    start_err = 1'b0; arbitration_err = 1'b0;
    tick();
    checks++;
    if ({core_w, resp_w, req_ready} !== {11'h000, 11'h000, 1'b1}) begin
      errors++; $display("FAIL idle_ignore got %h/%h/%b exp 000/000/1", core_w, resp_w, req_ready);
    end
    checks++;
    if (resp_seen != base) begin
      errors++; $display("FAIL idle_resp got %0d pulses exp 0", resp_seen - base);
    end
    $display("txn idle-ignore");
  endtask

  task automatic test_write();
    int base;
    base = resp_seen;
    accept(1'b0, 7'h50, 8'h10, 8'hA5);
    checks++;
    if ({core_w, req_ready} !== {1'b1, 1'b1, 1'b0, 8'hA0, 1'b0}) begin
      errors++; $display("FAIL wr_accept got %h/%b exp 6a0/0", core_w, req_ready);
    end
    complete(1'b0, 8'h00);  // ignored while waiting in ISSUE
    checks++;
    if (core_w !== {1'b1, 1'b1, 1'b0, 8'hA0}) begin
      errors++; $display("FAIL wr_issue_ignore got %h exp 6a0", core_w);
    end
    core_ready();
    checks++;
    if (core_w !== {1'b1, 1'b1, 1'b0, 8'hA0}) begin
      errors++; $display("FAIL wr_issue_hold got %h exp 6a0", core_w);
    end
    complete(1'b0, 8'h00);
    checks++;
    if (core_w !== {1'b1, 1'b1, 1'b0, 8'h10}) begin
      errors++; $display("FAIL wr_reg got %h exp 610", core_w);
    end
    complete(1'b0, 8'h00);
    checks++;
    if (core_w !== {1'b0, 1'b0, 1'b0, 8'hA5}) begin
      errors++; $display("FAIL wr_wdata got %h exp 0a5", core_w);
    end
    complete(1'b0, 8'h00);
    checks++;
    if (resp_valid !== 1'b0) begin
      errors++; $display("FAIL wr_early_resp got %b exp 0", resp_valid);
    end
    core_ready();
    checks++;
    if ({resp_valid, resp_err, req_ready} !== {1'b1, 2'b00, 1'b1}) begin
      errors++; $display("FAIL wr_resp got %b%b/%b exp 100/1", resp_valid, resp_err, req_ready);
    end
    tick();
    checks++;
    if (resp_seen - base != 1 || resp_valid !== 1'b0) begin
      errors++; $display("FAIL wr_pulse_count got %0d exp 1", resp_seen - base);
    end
    $display("txn write dev=50 reg=10 wdata=a5 err=%b", resp_err);
  endtask

  task automatic test_read();
    int base;
    base = resp_seen;
    accept(1'b1, 7'h50, 8'h02, 8'h00);
    checks++;
    if (core_w !== {1'b1, 1'b1, 1'b0, 8'hA0}) begin
      errors++; $display("FAIL rd_accept got %h exp 6a0", core_w);
    end
    core_ready();
    complete(1'b0, 8'h00);
    checks++;
    if (core_w !== {1'b1, 1'b0, 1'b0, 8'h02}) begin
      errors++; $display("FAIL rd_reg got %h exp 402", core_w);
    end
    complete(1'b0, 8'h00);
    checks++;
    if (core_w !== {1'b0, 1'b1, 1'b0, 8'hA1}) begin
      errors++; $display("FAIL rd_addr_r got %h exp 2a1", core_w);
    end
    complete(1'b0, 8'h00);
    checks++;
    if (core_w !== {1'b0, 1'b0, 1'b1, 8'hA1}) begin
      errors++; $display("FAIL rd_rdata got %h exp 1a1", core_w);
    end
    complete(1'b0, 8'h3C);
    tick();  // core not ready yet: response must wait
    checks++;
    if ({resp_valid, resp_rdata} !== {1'b0, 8'h3C}) begin
      errors++; $display("FAIL rd_wait got %b/%h exp 0/3c", resp_valid, resp_rdata);
    end
    core_ready();
    checks++;
    if (resp_w !== {1'b1, 2'b00, 8'h3C}) begin
      errors++; $display("FAIL rd_resp got %h exp 43c", resp_w);
    end
    tick();
    checks++;
    if (resp_seen - base != 1) begin
      errors++; $display("FAIL rd_pulse_count got %0d exp 1", resp_seen - base);
    end
    $display("txn read dev=50 reg=02 rdata=%h err=%b", resp_rdata, resp_err);
  endtask

  task automatic test_nack();
    accept(1'b0, 7'h50, 8'h10, 8'hA5);
    core_ready();
    complete(1'b1, 8'h00);
    checks++;
    if (core_w !== {1'b0, 1'b0, 1'b0, 8'hA0}) begin
      errors++; $display("FAIL nack_stop got %h exp 0a0", core_w);
    end
    complete(1'b0, 8'h00);
    tick();
    checks++;
    if ({core_w, resp_valid} !== {1'b0, 1'b0, 1'b0, 8'hA0, 1'b0}) begin
      errors++; $display("FAIL nack_no_phase got %h/%b exp 0a0/0", core_w, resp_valid);
    end
    core_ready();
    checks++;
    if ({resp_valid, resp_err} !== 3'b101) begin
      errors++; $display("FAIL nack_resp got %b%b exp 101", resp_valid, resp_err);
    end
    tick();
    $display("txn write-nack err=%b", resp_err);
  endtask

  task automatic test_arb();
    accept(1'b1, 7'h50, 8'h02, 8'h00);
    core_ready();
    complete(1'b0, 8'h00);
    arbitration_err = 1'b1; transaction_complete = 1'b1;
    tick();
    arbitration_err = 1'b0; transaction_complete = 1'b0;
    checks++;
    if (core_w !== {1'b0, 1'b0, 1'b0, 8'h02}) begin
      errors++; $display("FAIL arb_stop got %h exp 002", core_w);
    end
    complete(1'b0, 8'h00);
    checks++;
    if (core_w !== {1'b0, 1'b0, 1'b0, 8'h02}) begin
      errors++; $display("FAIL arb_no_addr_r got %h exp 002", core_w);
    end
    core_ready();
    checks++;
    if ({resp_valid, resp_err} !== 3'b110) begin
      errors++; $display("FAIL arb_resp got %b%b exp 110", resp_valid, resp_err);
    end
    tick();
    $display("txn read-arbitration err=%b", resp_err);
  endtask

  task automatic test_timeout();
    int base;
    base = resp_seen;
    accept(1'b0, 7'h50, 8'h10, 8'hA5);
    repeat (TO - 1) tick();
    checks++;
    if (resp_valid !== 1'b0 || resp_seen != base) begin
      errors++; $display("FAIL to_early got %b/%0d exp 0/0", resp_valid, resp_seen - base);
    end
    tick();
    checks++;
    if ({resp_valid, resp_err, transfer_start} !== 4'b1110) begin
      errors++; $display("FAIL to_resp got %b%b%b exp 1110", resp_valid, resp_err, transfer_start);
    end
    tick();
    checks++;
    if ({req_ready, resp_valid} !== 2'b10) begin
      errors++; $display("FAIL to_ready got %b%b exp 10", req_ready, resp_valid);
    end
    $display("txn timeout err=%b", resp_err);
  endtask

  task automatic test_reset_mid();
    int base;
    accept(1'b1, 7'h50, 8'h02, 8'h00);
    core_ready();
    repeat (3) complete(1'b0, 8'h00);
    checks++;
    if (mode !== 1'b1) begin
      errors++; $display("FAIL rm_in_rdata got mode %b exp 1", mode);
    end
    base = resp_seen;
    #2 reset_n = 1'b0;
    #1;
    checks++;
    if ({core_w, resp_w, req_ready} !== {11'h000, 11'h000, 1'b1}) begin
      errors++; $display("FAIL rm_async got %h/%h/%b exp 000/000/1", core_w, resp_w, req_ready);
    end
    transfer_ready = 1'b1;
    tick();
    reset_n = 1'b1;
    repeat (2) tick();
    transfer_ready = 1'b0;
    checks++;
    if (resp_seen != base) begin
      errors++; $display("FAIL rm_no_resp got %0d pulses exp 0", resp_seen - base);
    end
    $display("txn reset-mid-read abandoned");
  endtask

  task automatic test_back_to_back();
    accept(1'b0, 7'h50, 8'h10, 8'hA5);
    core_ready();
    repeat (3) complete(1'b0, 8'h00);
    core_ready();
    checks++;
    if ({resp_valid, resp_err, req_ready} !== 4'b1001) begin
      errors++; $display("FAIL b2b_first got %b%b%b exp 1001", resp_valid, resp_err, req_ready);
    end
    accept(1'b0, 7'h21, 8'h33, 8'h5A);
    checks++;
    if (core_w !== {1'b1, 1'b1, 1'b0, 8'h42}) begin
      errors++; $display("FAIL b2b_accept got %h exp 642", core_w);
    end
    start_err = 1'b1;
    tick();
    start_err = 1'b0;
    checks++;
    if (core_w !== {1'b0, 1'b0, 1'b0, 8'h42}) begin
      errors++; $display("FAIL b2b_start_err got %h exp 042", core_w);
    end
    core_ready();
    checks++;
    if ({resp_valid, resp_err} !== 3'b110) begin
      errors++; $display("FAIL b2b_resp got %b%b exp 110", resp_valid, resp_err);
    end
    tick();
    $display("txn back-to-back write then start_err err=%b", resp_err);
  endtask

  initial begin
    test_reset();
    test_idle_ignore();
    test_write();
    test_read();
    test_nack();
    test_arb();
    test_timeout();
    test_reset_mid();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
